pll_reset_seq: RTL
==================

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024: consecutive locked cycles required before the hold phase; legal range 1..65535.
REQ-002 Parameter HOLD_CYCLES, default 256: cycles reset is held after debounce completes; legal range 1..65535.
REQ-003 Port clk, input, 1: sole clock, normally a PLL output clock; all logic on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port pll_lockedn, input, 1: PLL lock indicator, active-low (0 = locked), asynchronous to clk.
REQ-006 Port rst_out, output, 1: registered system reset, active-high.
REQ-007 Port rst_n_out, output, 1: registered inverse of rst_out, for active-low consumers.
REQ-008 Port ready, output, 1: high only in state RUN.
REQ-009 Port lock_loss_cnt, output, 8: count of RUN-to-unlock events.

Function
REQ-010 pll_lockedn SHALL pass through a 2-flop synchronizer; locked_s = inverted output of the second flop.
REQ-011 The FSM SHALL have states WAIT_LOCK, DEBOUNCE, HOLD and RUN, plus one 16-bit cycle counter.
REQ-012 WAIT_LOCK: counter held at 0; locked_s=1 -> DEBOUNCE.
REQ-013 DEBOUNCE: counter increments each cycle; locked_s=0 -> WAIT_LOCK; counter==DEBOUNCE_CYCLES-1 with locked_s=1 -> HOLD, counter cleared.
REQ-014 HOLD: counter increments; locked_s=0 -> WAIT_LOCK; counter==HOLD_CYCLES-1 with locked_s=1 -> RUN.
REQ-015 RUN: locked_s=0 -> WAIT_LOCK; otherwise stay.
REQ-016 Unlock SHALL take priority over counter completion in the same cycle.
REQ-017 rst_out SHALL be registered as (next state != RUN); ready SHALL be registered as (next state == RUN); rst_n_out = !rst_out at all times.
REQ-018 Release latency: counting the first edge that samples pll_lockedn=0 as edge 1, rst_out SHALL fall on edge DEBOUNCE_CYCLES+HOLD_CYCLES+3, provided lock stays stable.
REQ-019 Assert latency: counting the first edge that samples pll_lockedn=1 in RUN as edge 1, rst_out SHALL rise on edge 3.
REQ-020 A lock glitch of any length during DEBOUNCE or HOLD SHALL restart sequencing from WAIT_LOCK with the counter at 0.

Reset
REQ-021 While rst=1, at each edge: state=WAIT_LOCK, counter=0, both synchronizer flops=unlocked, rst_out=1, rst_n_out=0, ready=0, lock_loss_cnt=0.
REQ-022 rst asserted mid-sequence or in RUN SHALL abort at the next edge with the REQ-021 values; sequencing restarts after rst falls.
REQ-023 rst SHALL take priority over all FSM transitions and counter updates.

Configuration
REQ-024 Macro PLL_RSTSEQ_LOSSCNT_EN defined: lock_loss_cnt increments by 1 on each RUN->WAIT_LOCK transition and saturates at 255.
REQ-025 Macro undefined: lock_loss_cnt is driven constant 0, no counter register is built, and all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3 unless stated)
REQ-026 rst high for 2 cycles, pll_lockedn=1 -> rst_out=1, rst_n_out=0, ready=0, lock_loss_cnt=0; state stays WAIT_LOCK indefinitely.
REQ-027 After reset, drive pll_lockedn=0 and hold it -> rst_out falls and ready rises on edge 10.
REQ-028 Lock, then drive pll_lockedn=1 for 1 cycle during HOLD -> return to WAIT_LOCK; after lock is restored, the full 10-edge release latency applies again.
REQ-029 In RUN, drive pll_lockedn=1 -> rst_out rises on edge 3 and ready falls on edge 3; with the macro defined, lock_loss_cnt=1.
REQ-030 Macro defined, 257 lock/RUN/unlock cycles -> lock_loss_cnt=255 (saturated); then rst -> lock_loss_cnt=0.
REQ-031 Assert rst in RUN -> rst_out=1 at the next edge; release rst with lock held -> rst_out falls on edge 10 counted from the first post-reset edge.

Source files
------------

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock debounce / reset hold sequencer.
// Optional lock-loss counter enabled by defining PLL_RSTSEQ_LOSSCNT_EN.
module pll_reset_seq #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lockedn,
  output logic       rst_out,
  output logic       rst_n_out,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    DEBOUNCE  = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [1:0]  sync;
  logic        locked_s;
  logic        rst_out_d;
  logic        ready_d;

  // sync[1] is the second synchronizer flop; its reset value means "unlocked".
  assign locked_s  = ~sync[1];
  assign rst_n_out = ~rst_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      cnt     <= 16'd0;
      sync    <= 2'b11;
      rst_out <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sync    <= {sync[0], pll_lockedn};
      rst_out <= rst_out_d;
      ready   <= ready_d;
    end
  end

  // Unlock is tested before counter completion so a coincident glitch always restarts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = 16'd0;
        if (locked_s) state_nxt = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = 16'd0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = 16'd0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = 16'd0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_comb begin
    rst_out_d = (state_nxt != RUN);
    ready_d   = (state_nxt == RUN);
  end

`ifdef PLL_RSTSEQ_LOSSCNT_EN
  logic       loss_inc;
  logic [7:0] loss_q;

  assign loss_inc      = (state == RUN) && (state_nxt == WAIT_LOCK);
  assign lock_loss_cnt = loss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q <= 8'd0;
    end else if (loss_inc && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
